// File: rtl/alu_hilo_issue_pkg.sv
// Shared control bundle, ALU function codes and HI/LO classification helpers
// for the execute-stage issue register.
package alu_hilo_issue_pkg;

    typedef struct packed {
        logic clk;
        logic rst;
    } data_control_t;

    typedef enum logic [4:0] {
        alu_func_none,
        alu_func_add,
        alu_func_sub,
        alu_func_and,
        alu_func_or,
        alu_func_xor,
        alu_func_nor,
        alu_func_slt,
        alu_func_sltu,
        alu_func_sll,
        alu_func_srl,
        alu_func_sra,
        alu_func_mfhi,
        alu_func_mflo,
        alu_func_mthi,
        alu_func_mtlo,
        alu_func_mulu,
        alu_func_mult
    } alu_func_t;

    function automatic logic data_control_clock(input data_control_t c);
        return c.clk;
    endfunction

    function automatic logic data_control_reset(input data_control_t c);
        return c.rst;
    endfunction

    function automatic logic alu_func_is_mul(input alu_func_t f);
        return (f == alu_func_mulu) || (f == alu_func_mult);
    endfunction

    // Anything that reads or writes the HI/LO pair, multiplies included.
    function automatic logic alu_func_is_hilo(input alu_func_t f);
        return (f == alu_func_mfhi) || (f == alu_func_mflo) ||
               (f == alu_func_mthi) || (f == alu_func_mtlo) ||
               alu_func_is_mul(f);
    endfunction

endpackage

// File: rtl/alu_hilo_scoreboard.sv
// Tracks the in-flight multiply: counts down the multiply latency and flags
// HI/LO accesses that must wait for the result.
module alu_hilo_scoreboard #(
    parameter int unsigned DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mul_accept,
    input  logic hilo_req,
    output logic hilo_busy,
    output logic hazard_gt1
);

    localparam int unsigned CNT_W = $clog2(DELAY + 1);

    typedef enum logic {
        st_idle,
        st_busy
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_idle;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A new multiply always reloads, even when the previous one is on its last cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (mul_accept) begin
            cnt_next   = CNT_W'(DELAY);
            state_next = st_busy;
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_next = st_idle;
            end
        end
    end

    assign hilo_busy  = (state == st_busy);
    // At cnt == 1 the result is valid by the time the next op reaches the ALU.
    assign hazard_gt1 = hilo_req && (cnt > CNT_W'(1));

endmodule

// File: rtl/alu_hilo_issue.sv
// Execute-stage issue register ahead of the HI/LO ALU: registers operands and
// holds back HI/LO operations while a multiply result is still pending.
module alu_hilo_issue
    import alu_hilo_issue_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DELAY   = 2,
    parameter int unsigned SHAMT_W = 5
) (
    input  data_control_t        ctrl,
    input  logic                 flush,
    input  logic                 out_stall,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  alu_func_t            in_func,
    input  logic [DATA_W-1:0]    in_data1,
    input  logic [DATA_W-1:0]    in_data2,
    input  logic [SHAMT_W-1:0]   in_shamt,
    output logic                 out_valid,
    output alu_func_t            out_func,
    output logic [DATA_W-1:0]    out_data1,
    output logic [DATA_W-1:0]    out_data2,
    output logic [SHAMT_W-1:0]   out_shamt,
    output logic                 hilo_busy
);

    logic clk;
    logic rst;
    logic hazard;
    logic accept;
    logic mul_accept;
    logic hilo_req;

    assign clk = data_control_clock(ctrl);
    assign rst = data_control_reset(ctrl);

    assign hilo_req   = in_valid && alu_func_is_hilo(in_func);
    assign in_ready   = !flush && !out_stall && !hazard;
    assign accept     = in_valid && in_ready;
    assign mul_accept = accept && alu_func_is_mul(in_func);

    alu_hilo_scoreboard #(
        .DELAY(DELAY)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .mul_accept(mul_accept),
        .hilo_req  (hilo_req),
        .hilo_busy (hilo_busy),
        .hazard_gt1(hazard)
    );

    // Output register: flush beats stall, stall beats accept, anything else is a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_func  <= alu_func_none;
            out_data1 <= '0;
            out_data2 <= '0;
            out_shamt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_func  <= alu_func_none;
            out_data1 <= '0;
            out_data2 <= '0;
            out_shamt <= '0;
        end else if (out_stall) begin
            out_valid <= out_valid;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_func  <= in_func;
            out_data1 <= in_data1;
            out_data2 <= in_data2;
            out_shamt <= in_shamt;
        end else begin
            out_valid <= 1'b0;
            out_func  <= alu_func_none;
            out_data1 <= '0;
            out_data2 <= '0;
            out_shamt <= '0;
        end
    end

endmodule

// File: tb/tb_alu_hilo_issue.sv
// Bench for alu_hilo_issue: two instances (DELAY 2 and 3) share one stimulus
// stream and are compared every cycle against a timestamp-based model.
module tb_alu_hilo_issue;
    import alu_hilo_issue_pkg::*;

    localparam int unsigned DW   = 4;
    localparam int unsigned SW   = 2;
    localparam int          DLY0 = 2;
    localparam int          DLY1 = 3;

    logic          clk;
    logic          rst;
    data_control_t ctrl;
    logic          flush;
    logic          out_stall;
    logic          in_valid;
    alu_func_t     in_func;
    logic [DW-1:0] in_data1;
    logic [DW-1:0] in_data2;
    logic [SW-1:0] in_shamt;

    logic          in_ready  [2];
    logic          out_valid [2];
    alu_func_t     out_func  [2];
    logic [DW-1:0] out_data1 [2];
    logic [DW-1:0] out_data2 [2];
    logic [SW-1:0] out_shamt [2];
    logic          hilo_busy [2];

    int errors;
    int checks;

    assign ctrl = '{clk: clk, rst: rst};

    alu_hilo_issue #(.DATA_W(DW), .DELAY(DLY0), .SHAMT_W(SW)) u_dut0 (
        .ctrl(ctrl), .flush(flush), .out_stall(out_stall),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_func(in_func),
        .in_data1(in_data1), .in_data2(in_data2), .in_shamt(in_shamt),
        .out_valid(out_valid[0]), .out_func(out_func[0]),
        .out_data1(out_data1[0]), .out_data2(out_data2[0]),
        .out_shamt(out_shamt[0]), .hilo_busy(hilo_busy[0])
    );

    alu_hilo_issue #(.DATA_W(DW), .DELAY(DLY1), .SHAMT_W(SW)) u_dut1 (
        .ctrl(ctrl), .flush(flush), .out_stall(out_stall),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_func(in_func),
        .in_data1(in_data1), .in_data2(in_data2), .in_shamt(in_shamt),
        .out_valid(out_valid[1]), .out_func(out_func[1]),
        .out_data1(out_data1[1]), .out_data2(out_data2[1]),
        .out_shamt(out_shamt[1]), .hilo_busy(hilo_busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a multiply accepted at edge t keeps HI/LO pending until edge t+DELAY.
    int        cyc;
    int        last_mul [2];
    logic      m_valid  [2];
    alu_func_t m_func   [2];
    int        m_d1     [2];
    int        m_d2     [2];
    int        m_sh     [2];

    function automatic int remaining(input int i);
        int v;
        v = last_mul[i] + ((i == 0) ? DLY0 : DLY1) - cyc;
        return (v > 0) ? v : 0;
    endfunction

    function automatic logic is_hilo(input alu_func_t f);
        return f inside {alu_func_mfhi, alu_func_mflo, alu_func_mthi,
                         alu_func_mtlo, alu_func_mulu, alu_func_mult};
    endfunction

    function automatic logic model_ready(input int i);
        logic haz;
        haz = in_valid && is_hilo(in_func) && (remaining(i) > 1);
        return !flush && !out_stall && !haz;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            last_mul[i] = -100;
            m_valid[i]  = 1'b0;
            m_func[i]   = alu_func_none;
            m_d1[i]     = 0;
            m_d2[i]     = 0;
            m_sh[i]     = 0;
        end
    endtask

    initial begin
        cyc = 0;
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    logic acc;
                    acc = in_valid && model_ready(i);
                    if (flush || (!out_stall && !acc)) begin
                        m_valid[i] = 1'b0;
                        m_func[i]  = alu_func_none;
                        m_d1[i]    = 0;
                        m_d2[i]    = 0;
                        m_sh[i]    = 0;
                    end else if (!out_stall) begin
                        m_valid[i] = 1'b1;
                        m_func[i]  = in_func;
                        m_d1[i]    = int'(in_data1);
                        m_d2[i]    = int'(in_data2);
                        m_sh[i]    = int'(in_shamt);
                    end
                    if (acc && (in_func == alu_func_mulu || in_func == alu_func_mult))
                        last_mul[i] = cyc + 1;
                end
                cyc++;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("cmp%0d_valid", i), int'(out_valid[i]), int'(m_valid[i]));
                check($sformatf("cmp%0d_func", i), int'(out_func[i]), int'(m_func[i]));
                check($sformatf("cmp%0d_d1", i), int'(out_data1[i]), m_d1[i]);
                check($sformatf("cmp%0d_d2", i), int'(out_data2[i]), m_d2[i]);
                check($sformatf("cmp%0d_shamt", i), int'(out_shamt[i]), m_sh[i]);
                check($sformatf("cmp%0d_busy", i), int'(hilo_busy[i]), int'(remaining(i) > 0));
                check($sformatf("cmp%0d_ready", i), int'(in_ready[i]), int'(model_ready(i)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_func_t f, input int d1, input int d2, input int sh);
        in_valid = 1'b1;
        in_func  = f;
        in_data1 = DW'(d1);
        in_data2 = DW'(d2);
        in_shamt = SW'(sh);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_func  = alu_func_none;
        in_data1 = '0;
        in_data2 = '0;
        in_shamt = '0;
        repeat (n) step();
    endtask

    // Mulu then Mfhi held until instance `inst` accepts it; returns the stall cycles seen.
    task automatic interlock(input int inst, input int exp_stalls);
        int stalls;
        idle(4);
        drive(alu_func_mulu, 10, 10, 0);
        step();
        drive(alu_func_mfhi, 0, 0, 0);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (in_ready[inst]) break;
            stalls++;
            step();
        end
        check($sformatf("interlock%0d_stalls", inst), stalls, exp_stalls);
        step();
        idle(0);
        @(negedge clk);
        check($sformatf("interlock%0d_mfhi_out", inst), int'(out_func[inst]), int'(alu_func_mfhi));
        step();
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; flush = 1'b0; out_stall = 1'b0;
        in_valid = 1'b0; in_func = alu_func_none;
        in_data1 = '0; in_data2 = '0; in_shamt = '0;

        // Reset held two cycles
        repeat (2) step();
        @(negedge clk);
        check("rst_valid", int'(out_valid[0]), 0);
        check("rst_func", int'(out_func[0]), int'(alu_func_none));
        check("rst_busy", int'(hilo_busy[0]), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(in_ready[0]), 1);
        step();

        // Pass-through
        drive(alu_func_add, 7, 3, 0);
        @(negedge clk);
        check("pass_ready_add", int'(in_ready[0]), 1);
        step();
        drive(alu_func_xor, 15, 15, 0);
        @(negedge clk);
        check("pass_add_func", int'(out_func[0]), int'(alu_func_add));
        check("pass_add_d1", int'(out_data1[0]), 7);
        check("pass_add_d2", int'(out_data2[0]), 3);
        check("pass_add_valid", int'(out_valid[0]), 1);
        check("pass_ready_xor", int'(in_ready[0]), 1);
        step();
        idle(0);
        @(negedge clk);
        check("pass_xor_func", int'(out_func[0]), int'(alu_func_xor));
        check("pass_xor_d1", int'(out_data1[0]), 15);
        check("pass_xor_valid", int'(out_valid[0]), 1);
        step();
        @(negedge clk);
        check("pass_idle_bubble", int'(out_valid[0]), 0);

        // Interlock: DELAY-1 stall cycles per instance
        interlock(0, DLY0 - 1);
        interlock(1, DLY1 - 1);

        // Independence: non-HI/LO op slips in, then Mflo needs no bubble
        idle(4);
        drive(alu_func_mulu, 2, 3, 0);
        step();
        drive(alu_func_sll, 5, 0, 1);
        @(negedge clk);
        check("indep_sll_ready", int'(in_ready[0]), 1);
        step();
        drive(alu_func_mflo, 0, 0, 0);
        @(negedge clk);
        check("indep_mflo_ready", int'(in_ready[0]), 1);
        check("indep_sll_func", int'(out_func[0]), int'(alu_func_sll));
        check("indep_sll_d1", int'(out_data1[0]), 5);
        check("indep_sll_shamt", int'(out_shamt[0]), 1);
        step();
        idle(0);
        @(negedge clk);
        check("indep_mflo_func", int'(out_func[0]), int'(alu_func_mflo));

        // Stall holds the output for two cycles
        idle(4);
        drive(alu_func_sra, 10, 3, 2);
        step();
        out_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_ready", int'(in_ready[0]), 0);
            check("stall_func", int'(out_func[0]), int'(alu_func_sra));
            check("stall_d1", int'(out_data1[0]), 10);
            step();
        end
        out_stall = 1'b0;
        drive(alu_func_add, 1, 2, 0);
        step();
        flush = 1'b1;
        out_stall = 1'b1;
        step();
        @(negedge clk);
        check("flush_stall_valid", int'(out_valid[0]), 0);
        check("flush_stall_func", int'(out_func[0]), int'(alu_func_none));
        flush = 1'b0;
        out_stall = 1'b0;
        idle(4);

        // Flush does not cancel the multiply countdown
        drive(alu_func_mulu, 3, 3, 0);
        step();
        idle(0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_e1", int'(hilo_busy[0]), 1);
        step();
        @(negedge clk);
        check("flush_busy_e2", int'(hilo_busy[0]), 1);
        step();
        @(negedge clk);
        check("flush_busy_e3", int'(hilo_busy[0]), 0);
        check("flush_busy_e3_d3", int'(hilo_busy[1]), 1);
        flush = 1'b0;
        idle(4);

        // Reset the cycle after a multiply
        drive(alu_func_mulu, 4, 4, 0);
        step();
        idle(0);
        rst = 1'b1;
        #1;
        check("rstmid_busy0", int'(hilo_busy[0]), 0);
        check("rstmid_busy1", int'(hilo_busy[1]), 0);
        step();
        rst = 1'b0;
        drive(alu_func_mfhi, 0, 0, 0);
        @(negedge clk);
        check("rstmid_ready0", int'(in_ready[0]), 1);
        check("rstmid_ready1", int'(in_ready[1]), 1);
        step();
        idle(0);
        @(negedge clk);
        check("rstmid_mfhi0", int'(out_func[0]), int'(alu_func_mfhi));
        check("rstmid_mfhi1", int'(out_func[1]), int'(alu_func_mfhi));
        step();

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 2000; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 8);
            out_stall = ($urandom_range(0, 99) < 15);
            in_valid  = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 1) == 1)
                in_func = alu_func_t'(5'($urandom_range(12, 17)));
            else
                in_func = alu_func_t'(5'($urandom_range(0, 17)));
            in_data1 = DW'($urandom);
            in_data2 = DW'($urandom);
            in_shamt = SW'($urandom);
            step();
        end
        rst = 1'b0; flush = 1'b0; out_stall = 1'b0;
        idle(2);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_hilo_issue.md
# alu_hilo_issue

Execute-stage issue register placed directly upstream of `Alu_hilo`. It registers the ALU operands, function and shift amount from decode/forwarding. It interlocks HI/LO readers and writers behind an in-flight multiply by inserting bubbles until the multiply result is valid. Non-HI/LO operations keep flowing while a multiply is in flight.

## Interface
Parameters:
- `DATA_W`, 32, operand width; must equal the downstream `Alu_hilo` `DATA_W`
- `DELAY`, 2, multiply latency in cycles; must equal the downstream `Alu_hilo` `DELAY`; legal values ≥ 1
- `SHAMT_W`, 5, shift-amount width

Ports:
- `ctrl`  in  `Data_Control_T`  control bundle
  - Clock is `Data_Control_Clock(ctrl)`.
  - Reset is `Data_Control_Reset(ctrl)`: one clock; reset is asynchronous and active-high.
- `flush`  in  1  synchronous pipeline flush (branch/exception)
- `out_stall`  in  1  downstream (MEM) stall; holds the output register
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  instruction accepted this cycle when `in_valid && in_ready`
- `in_func`  in  `Alu_Func_T`  ALU function
- `in_data1`, `in_data2`  in  DATA_W  operands
- `in_shamt`  in  SHAMT_W  shift amount
- `out_valid`  out  1  output register holds a real instruction
- `out_func`  out  `Alu_Func_T`  to `Alu_hilo.func`; `Alu_Func_None` when not valid
- `out_data1`, `out_data2`  out  DATA_W  to `Alu_hilo.data1`/`data2`
- `out_shamt`  out  SHAMT_W  to `Alu_hilo.shamt`
- `hilo_busy`  out  1  multiply in flight (`cnt != 0`)

## Operation
- **HI/LO ops**: `Mfhi`, `Mflo`, `Mthi`, `Mtlo`, `Mulu`, `Mult`.
- **Multiply ops**: `Mulu`, `Mult`.
- **Counter** `cnt`, width `$clog2(DELAY+1)`:
  - Loads `DELAY` on the edge that accepts a multiply.
  - Otherwise decrements when nonzero and saturates at 0.
  - Flush and `out_stall` do not affect it; an issued multiply always completes.
- **Hazard**: `in_valid && isHilo(in_func) && cnt > 1`.
- `in_ready = !flush && !out_stall && !hazard`.
- **Output register update, in priority order**:
  1. Reset: clear.
  2. `flush`: bubble.
  3. `out_stall`: hold.
  4. Accept: load the `in_*` fields and set `out_valid = 1`.
  5. Otherwise: bubble.
- **Bubble**: `out_valid = 0`, `out_func = Alu_Func_None`, `out_data1`/`out_data2`/`out_shamt` = 0.
- **States**: IDLE (`cnt == 0`) and BUSY (`cnt != 0`).
  - IDLE → BUSY on multiply accept.
  - BUSY → IDLE when `cnt` goes 1 → 0 with no new multiply accepted.
  - A multiply accepted at `cnt == 1` reloads `DELAY` and stays BUSY.

## Timing
- **Reset (async)**: `out_valid = 0`, `out_func = None`, data/shamt 0, `cnt = 0`, `hilo_busy = 0`. `in_ready` is combinational and is 1 once reset deasserts and there is no stall.
- **Latency**: 1 cycle from accept to `out_*`.
- **Throughput**: 1 per cycle with no hazard.
- **Back-to-back multiply → HI/LO op**: exactly `DELAY - 1` bubbles; 0 bubbles when `DELAY = 1`.
- **Simultaneous `flush` and `out_stall`**: flush wins; the output becomes a bubble.
- **Reset mid-multiply**: `cnt` clears immediately and the next HI/LO op is not stalled.
- **Non-HI/LO ops while BUSY**: accepted every cycle; `cnt` keeps decrementing.
- **`in_valid = 0`**: the output becomes a bubble unless `out_stall` is asserted.

## Structure
- Add to the shared Alu func header, next to the existing `Alu_Func_*` codes:
  - `Alu_Func_IsHilo(f)`
  - `Alu_Func_IsMul(f)`
- No new typedefs; reuse `Data_Control_T` and `Alu_Func_T`.
- One sub-module: `alu_hilo_scoreboard`. It holds the `cnt` counter and produces `hilo_busy` and `hazard_gt1`. The parent holds the output register and handshake.

## Test plan
(`DATA_W=4`, `DELAY=2`, `SHAMT_W=2`)
- **Reset**: hold reset 2 cycles → `out_valid=0`, `out_func=None`, `hilo_busy=0`. After release, `in_ready=1`.
- **Pass-through**: `Add` 7,3 then `Xor` f,f on consecutive cycles → `out_*` shows each exactly one cycle later, `out_valid=1` both cycles, `in_ready` never drops.
- **Interlock**: `Mulu` a,a then `Mfhi` back-to-back → `in_ready=0` for 1 cycle; one bubble (`out_func=None`); `Mfhi` appears 2 cycles after `Mulu`. Repeat with `DELAY=3` → 2 bubbles.
- **Independence**: `Mulu` then `Sll` 5/shamt 1 then `Mflo` → `Sll` accepted without stall; `Mflo` accepted with no bubble, since `cnt` is already 1.
- **Flush/stall**:
  - `out_stall` for 2 cycles holding `Sra` a → outputs held and `in_ready=0`.
  - `flush` together with `out_stall` → bubble next cycle.
  - `flush` during BUSY → `hilo_busy` still falls on schedule.
- **Reset mid-multiply**: reset asserted the cycle after `Mulu` → `hilo_busy=0` immediately; a following `Mfhi` is accepted without stall.
